// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decode inputs and stall/flush controls between the pipeline and its hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [31:0] fd_ir, dx_ir;
  logic branch_taken, multdiv_ready;
  logic pc_enable, fd_enable, dx_enable, fd_flush, dx_bubble, xm_bubble;
  logic multdiv_start, md_busy, md_error;
  modport master(
    output fd_ir, dx_ir, branch_taken, multdiv_ready,
    input pc_enable, fd_enable, dx_enable, fd_flush, dx_bubble, xm_bubble, multdiv_start, md_busy, md_error
  );
  modport slave(
    input fd_ir, dx_ir, branch_taken, multdiv_ready,
    output pc_enable, fd_enable, dx_enable, fd_flush, dx_bubble, xm_bubble, multdiv_start, md_busy, md_error
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: multdiv handshake FSM, branch flush and load-use interlock for the 5-stage pipeline.
// Define LOAD_USE_STALL_EN to compile in the load-use interlock.
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input logic clock,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic err, dx_md, load_use, timeout, busy, flush, lu;
  assign dx_md = hz.dx_ir[31:27] == 5'b00000 && (hz.dx_ir[6:2] == 5'b00110 || hz.dx_ir[6:2] == 5'b00111);
`ifdef LOAD_USE_STALL_EN
  logic [4:0] fd_op, ld_rd;
  logic reads_rs, reads_rt;
  assign fd_op = hz.fd_ir[31:27];
  assign ld_rd = hz.dx_ir[26:22];
  assign reads_rs = fd_op == 5'b00000 || fd_op == 5'b00101 || fd_op == 5'b01000 || fd_op == 5'b00111;
  assign reads_rt = fd_op == 5'b00000;
  assign load_use = hz.dx_ir[31:27] == 5'b01000 && ld_rd != 5'd0 &&
                    ((reads_rs && hz.fd_ir[21:17] == ld_rd) || (reads_rt && hz.fd_ir[16:12] == ld_rd));
`else
  assign load_use = 1'b0;
`endif
  assign timeout = cnt == 6'(MD_TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state == BUSY && state_nx == BUSY) ? cnt + 6'd1 : 6'd0;
      err <= err | (state == BUSY && !hz.multdiv_ready && timeout);
    end
  end
  always_comb begin
    state_nx = state == BUSY ? ((hz.multdiv_ready || timeout) ? DONE : BUSY) :
               state == DONE ? IDLE :
               (dx_md && !hz.branch_taken) ? BUSY : IDLE;
  end
  // Reset gates every term so the pipeline sees plain "run" controls while held in reset.
  always_comb begin
    busy = !reset && state == BUSY;
    flush = !reset && !busy && hz.branch_taken;
    lu = !reset && !busy && !hz.branch_taken && load_use;
    hz.pc_enable = !(busy || lu);
    hz.fd_enable = !(busy || lu);
    hz.dx_enable = !busy;
    hz.fd_flush = flush;
    hz.dx_bubble = flush || lu;
    hz.xm_bubble = busy;
    hz.multdiv_start = !reset && state == IDLE && dx_md && !hz.branch_taken;
    hz.md_busy = busy;
    hz.md_error = err && !reset;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed test-plan scenarios plus random traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int T = 40;
  logic clock = 1'b0, reset;
  int n_tests = 0, n_fail = 0, n_start = 0, n_busy = 0;
  bit in_busy = 0, in_done = 0, m_err = 0;
  int waited = 0;
  pipeline_hazard_ctrl_if hz();
  pipeline_hazard_ctrl #(.MD_TIMEOUT(T)) dut (.clock(clock), .reset(reset), .hz(hz));
  always #5 clock = ~clock;

  function automatic logic [31:0] enc(input int op, rd, rs, rt, alu);
    return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction
  function automatic bit is_md(input logic [31:0] ir);
    return ir[31:27] == 0 && (ir[6:2] == 6 || ir[6:2] == 7);
  endfunction
  function automatic bit hazard(input logic [31:0] f, d);
`ifdef LOAD_USE_STALL_EN
    int r = d[26:22];
    int op = f[31:27];
    if (d[31:27] != 8 || r == 0) return 0;
    return ((op == 0 || op == 5 || op == 7 || op == 8) && f[21:17] == r) || (op == 0 && f[16:12] == r);
`else
    return 0;
`endif
  endfunction
  // order: pc_en fd_en dx_en fd_flush dx_bubble xm_bubble start busy err
  function automatic logic [8:0] expect_ctl(input logic [31:0] f, d, input bit b, rs);
    if (rs) return 9'b111_000_000;
    if (in_busy) return {8'b000_001_01, m_err};
    if (b) return {8'b111_110_00, m_err};
    if (hazard(f, d)) return {8'b001_010_00, m_err};
    return {6'b111_000, !in_done && is_md(d), 1'b0, m_err};
  endfunction
  function automatic logic [8:0] observed();
    return {hz.pc_enable, hz.fd_enable, hz.dx_enable, hz.fd_flush, hz.dx_bubble,
            hz.xm_bubble, hz.multdiv_start, hz.md_busy, hz.md_error};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input string tag, input logic [31:0] f, d, input bit b, rdy, rs);
    @(negedge clock);
    hz.fd_ir = f;
    hz.dx_ir = d;
    hz.branch_taken = b;
    hz.multdiv_ready = rdy;
    reset = rs;
    #1;
    check(tag, observed(), expect_ctl(f, d, b, rs));
    n_start += int'(hz.multdiv_start);
    n_busy += int'(hz.md_busy);
    @(posedge clock);
    if (rs) begin
      in_busy = 0; in_done = 0; waited = 0; m_err = 0;
    end else if (in_busy) begin
      waited++;
      if (rdy || waited == T) begin
        m_err = m_err | !rdy;
        in_busy = 0;
        in_done = 1;
      end
    end else if (in_done) in_done = 0;
    else if (is_md(d) && !b) begin
      in_busy = 1;
      waited = 0;
    end
  endtask

  function automatic logic [31:0] rand_ir();
    int k = $urandom_range(0, 5);
    int op = k == 0 || k == 4 ? 0 : k == 1 ? 5 : k == 2 ? 7 : k == 3 ? 8 : $urandom_range(0, 31);
    int alu = k == 4 ? 6 + $urandom_range(0, 1) : $urandom_range(0, 7);
    return enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), alu);
  endfunction

  initial begin
    logic [31:0] nop, mul, dv, lw5, add6, lw0;
    bit quiet;
    nop = 0;
    mul = enc(0, 3, 1, 2, 6);
    dv = enc(0, 4, 1, 2, 7);
    lw5 = enc(8, 5, 2, 0, 0);
    add6 = enc(0, 6, 5, 7, 0);
    lw0 = enc(8, 0, 2, 0, 0);
    repeat (2) tick("reset", nop, nop, 0, 0, 1);
    n_start = 0; n_busy = 0;
    tick("mul_start", nop, mul, 0, 0, 0);
    repeat (4) tick("mul_busy", nop, mul, 0, 0, 0);
    tick("mul_ready", nop, mul, 0, 1, 0);
    tick("mul_done", nop, mul, 0, 0, 0);
    repeat (3) tick("mul_idle", nop, nop, 0, 0, 0);
    check("mul_starts", 9'(n_start), 9'd1);
    check("mul_busy_cycles", 9'(n_busy), 9'd5);
    n_busy = 0;
    tick("wd_start", nop, mul, 0, 1, 0);
    repeat (T + 1) tick("wd_busy_done", nop, mul, 0, 0, 0);
    check("wd_busy_cycles", 9'(n_busy), 9'(T));
    repeat (3) tick("wd_sticky", nop, nop, 0, 0, 0);
    check("wd_err", {8'd0, hz.md_error}, 9'd1);
    tick("rst_mid_start", nop, dv, 0, 0, 0);
    repeat (2) tick("rst_mid_busy", nop, dv, 0, 0, 0);
    repeat (2) tick("rst_mid", nop, dv, 0, 0, 1);
    tick("rst_after", nop, nop, 0, 0, 0);
    check("rst_err_clear", {8'd0, hz.md_error}, 9'd0);
    tick("load_use", add6, lw5, 0, 0, 0);
    tick("load_use_after", add6, nop, 0, 0, 0);
    tick("load_use_r0", enc(0, 6, 0, 7, 0), lw0, 0, 0, 0);
    tick("load_use_rt", enc(0, 6, 1, 5, 0), lw5, 0, 0, 0);
    tick("branch_vs_div", nop, dv, 1, 0, 0);
    tick("branch_vs_div_idle", nop, nop, 0, 0, 0);
    tick("branch_vs_lu", add6, lw5, 1, 0, 0);
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) quiet = $urandom_range(0, 2) == 0;
      tick("random", rand_ir(), rand_ir(), $urandom_range(0, 7) == 0,
           !quiet && $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
